// File: rtl/riscv_soft_mem_arbiter.sv
// riscv_soft_mem_arbiter
// Shares the single external memory port between the icache refill path and
// the dcache path. Round-robin grant with a lock that holds the memory-side
// request stable while it is stalled, plus an in-order owner FIFO that steers
// each memory response back to the requester that issued it.
module riscv_soft_mem_arbiter #(
    parameter int ADDR_LEN        = 32,
    parameter int XPR_LEN         = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic                               icache_mem_req_valid,
    output logic                               icache_mem_req_ready,
    input  logic [ADDR_LEN-1:0]                icache_mem_req_addr,
    output logic                               icache_mem_resp_valid,
    output logic [XPR_LEN-1:0]                 icache_mem_resp_data,

    input  logic                               dcache_mem_req_valid,
    output logic                               dcache_mem_req_ready,
    input  logic [ADDR_LEN-1:0]                dcache_mem_req_addr,
    input  logic [1:0]                         dcache_mem_req_op,
    input  logic [XPR_LEN-1:0]                 dcache_mem_req_wdata,
    input  logic [3:0]                         dcache_mem_req_wmask,
    output logic                               dcache_mem_resp_valid,
    output logic [XPR_LEN-1:0]                 dcache_mem_resp_data,

    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [ADDR_LEN-1:0]                mem_req_addr,
    output logic [1:0]                         mem_req_op,
    output logic [XPR_LEN-1:0]                 mem_req_wdata,
    output logic [3:0]                         mem_req_wmask,
    input  logic                               mem_resp_valid,
    input  logic [XPR_LEN-1:0]                 mem_resp_data,

    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               proto_err
);

    localparam int              PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [1:0]      MEM_LOAD = 2'd0;

    // Owner encoding: 0 = icache, 1 = dcache.
    logic                       last_grant;
    logic                       lock;
    logic                       lock_owner;
    logic [MAX_OUTSTANDING-1:0] owner_fifo;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;

    logic grant_active;
    logic grant_sel;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head;

    // Grant selection: lock wins, then a lone requester, then round-robin on ties.
    always_comb begin
        grant_active = 1'b0;
        grant_sel    = 1'b0;
        if (reset) begin
            grant_active = 1'b0;
        end else if (lock) begin
            grant_active = 1'b1;
            grant_sel    = lock_owner;
        end else if (icache_mem_req_valid && dcache_mem_req_valid) begin
            grant_active = 1'b1;
            grant_sel    = ~last_grant;
        end else if (icache_mem_req_valid) begin
            grant_active = 1'b1;
            grant_sel    = 1'b0;
        end else if (dcache_mem_req_valid) begin
            grant_active = 1'b1;
            grant_sel    = 1'b1;
        end
    end

    // A pop in the same cycle does not lift "full"; this keeps the request path
    // independent of the response path.
    assign full  = (count == MAX_CNT);
    assign empty = (count == '0);

    assign mem_req_valid = grant_active && !full &&
                           (grant_sel ? dcache_mem_req_valid : icache_mem_req_valid);

    assign icache_mem_req_ready = grant_active && !grant_sel && mem_req_ready && !full;
    assign dcache_mem_req_ready = grant_active &&  grant_sel && mem_req_ready && !full;

    // Memory-side fields follow the grant; icache refills are always plain loads.
    always_comb begin
        if (grant_sel) begin
            mem_req_addr  = dcache_mem_req_addr;
            mem_req_op    = dcache_mem_req_op;
            mem_req_wdata = dcache_mem_req_wdata;
            mem_req_wmask = dcache_mem_req_wmask;
        end else begin
            mem_req_addr  = icache_mem_req_addr;
            mem_req_op    = MEM_LOAD;
            mem_req_wdata = '0;
            mem_req_wmask = '0;
        end
    end

    assign push = mem_req_valid && mem_req_ready;
    assign pop  = mem_resp_valid && !empty;
    assign head = owner_fifo[rd_ptr];

    assign icache_mem_resp_valid = pop && !head;
    assign dcache_mem_resp_valid = pop &&  head;
    assign icache_mem_resp_data  = mem_resp_data;
    assign dcache_mem_resp_data  = mem_resp_data;

    assign outstanding = count;

    // Owner FIFO storage and pointers; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_fifo <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push) begin
                owner_fifo[wr_ptr] <= grant_sel;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // In-flight counter; push and pop together leave it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Round-robin history and stall lock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            lock       <= 1'b0;
            lock_owner <= 1'b0;
        end else if (push) begin
            last_grant <= grant_sel;
            lock       <= 1'b0;
        end else if (mem_req_valid && !mem_req_ready) begin
            lock       <= 1'b1;
            lock_owner <= grant_sel;
        end
    end

    // Sticky flag for a response that arrives with nothing in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (mem_resp_valid && empty) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_soft_mem_arbiter.sv
// Self-checking bench for riscv_soft_mem_arbiter: a table of per-cycle
// stimulus/expected-grant records plus hand-written multi-cycle sequences.
// Expected response owners are queued when a handshake is expected and
// popped when a response is driven.
module tb_riscv_soft_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        icache_mem_req_valid;
    logic        icache_mem_req_ready;
    logic [31:0] icache_mem_req_addr;
    logic        icache_mem_resp_valid;
    logic [31:0] icache_mem_resp_data;
    logic        dcache_mem_req_valid;
    logic        dcache_mem_req_ready;
    logic [31:0] dcache_mem_req_addr;
    logic [1:0]  dcache_mem_req_op;
    logic [31:0] dcache_mem_req_wdata;
    logic [3:0]  dcache_mem_req_wmask;
    logic        dcache_mem_resp_valid;
    logic [31:0] dcache_mem_resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [1:0]  mem_req_op;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [2:0]  outstanding;
    logic        proto_err;

    riscv_soft_mem_arbiter #(
        .ADDR_LEN(32), .XPR_LEN(32), .MAX_OUTSTANDING(4)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .icache_mem_req_valid  (icache_mem_req_valid),
        .icache_mem_req_ready  (icache_mem_req_ready),
        .icache_mem_req_addr   (icache_mem_req_addr),
        .icache_mem_resp_valid (icache_mem_resp_valid),
        .icache_mem_resp_data  (icache_mem_resp_data),
        .dcache_mem_req_valid  (dcache_mem_req_valid),
        .dcache_mem_req_ready  (dcache_mem_req_ready),
        .dcache_mem_req_addr   (dcache_mem_req_addr),
        .dcache_mem_req_op     (dcache_mem_req_op),
        .dcache_mem_req_wdata  (dcache_mem_req_wdata),
        .dcache_mem_req_wmask  (dcache_mem_req_wmask),
        .dcache_mem_resp_valid (dcache_mem_resp_valid),
        .dcache_mem_resp_data  (dcache_mem_resp_data),
        .mem_req_valid         (mem_req_valid),
        .mem_req_ready         (mem_req_ready),
        .mem_req_addr          (mem_req_addr),
        .mem_req_op            (mem_req_op),
        .mem_req_wdata         (mem_req_wdata),
        .mem_req_wmask         (mem_req_wmask),
        .mem_resp_valid        (mem_resp_valid),
        .mem_resp_data         (mem_resp_data),
        .outstanding           (outstanding),
        .proto_err             (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        dv;
        logic        mr;
        logic        rv;
        logic [31:0] rdata;
        logic        exp_mv;
        logic        exp_gnt;
    } vec_t;

    int    checks = 0;
    int    passed = 0;
    string tag    = "reset";
    logic  sb[$];
    logic  exp_proto = 1'b0;
    vec_t  tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s.%s actual=%h required=%h", tag, name, act, req);
    endtask

    function automatic vec_t mk(input logic iv, input logic dv, input logic mr, input logic rv,
                                input logic [31:0] rdata, input logic exp_mv, input logic exp_gnt);
        vec_t v;
        v.iv = iv; v.dv = dv; v.mr = mr; v.rv = rv;
        v.rdata = rdata; v.exp_mv = exp_mv; v.exp_gnt = exp_gnt;
        return v;
    endfunction

    // One clock cycle: drive at posedge+1, sample combinational outputs at
    // posedge+4, check registered state at the following posedge+1.
    task automatic step(input logic iv, input logic dv, input logic mr, input logic rv,
                        input logic [31:0] rdata, input logic exp_mv, input logic exp_gnt);
        logic o;
        icache_mem_req_valid = iv;
        dcache_mem_req_valid = dv;
        mem_req_ready        = mr;
        mem_resp_valid       = rv;
        mem_resp_data        = rdata;
        #3;
        chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_mv));
        chk("icache_ready", 32'(icache_mem_req_ready), 32'(exp_mv && mr && !exp_gnt));
        chk("dcache_ready", 32'(dcache_mem_req_ready), 32'(exp_mv && mr && exp_gnt));
        if (exp_mv) begin
            chk("addr",  mem_req_addr,         exp_gnt ? dcache_mem_req_addr : icache_mem_req_addr);
            chk("op",    32'(mem_req_op),      exp_gnt ? 32'(dcache_mem_req_op) : 32'd0);
            chk("wdata", mem_req_wdata,        exp_gnt ? dcache_mem_req_wdata : 32'd0);
            chk("wmask", 32'(mem_req_wmask),   exp_gnt ? 32'(dcache_mem_req_wmask) : 32'd0);
        end
        if (rv && sb.size() > 0) begin
            o = sb.pop_front();
            chk("icache_resp_valid", 32'(icache_mem_resp_valid), 32'(!o));
            chk("dcache_resp_valid", 32'(dcache_mem_resp_valid), 32'(o));
            chk("resp_data", o ? dcache_mem_resp_data : icache_mem_resp_data, rdata);
        end else begin
            if (rv) exp_proto = 1'b1;
            chk("icache_resp_valid", 32'(icache_mem_resp_valid), 32'd0);
            chk("dcache_resp_valid", 32'(dcache_mem_resp_valid), 32'd0);
        end
        if (exp_mv && mr) sb.push_back(exp_gnt);
        @(posedge clk);
        #1;
        chk("outstanding", 32'(outstanding), 32'(sb.size()));
        chk("proto_err", 32'(proto_err), 32'(exp_proto));
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'h5000_0000 + 32'(k), 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Round-robin table after reset (last grant = dcache).
        tbl[0]  = mk(0, 0, 1, 0, 32'h0,         0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 32'h0,         1, 0);
        tbl[2]  = mk(1, 1, 1, 0, 32'h0,         1, 1);
        tbl[3]  = mk(1, 1, 1, 0, 32'h0,         1, 0);
        tbl[4]  = mk(1, 1, 1, 0, 32'h0,         1, 1);
        tbl[5]  = mk(1, 1, 1, 0, 32'h0,         0, 0);
        tbl[6]  = mk(1, 1, 1, 1, 32'h1111_0006, 0, 0);
        tbl[7]  = mk(1, 1, 1, 0, 32'h0,         1, 0);
        tbl[8]  = mk(0, 1, 1, 1, 32'h1111_0008, 0, 0);
        tbl[9]  = mk(0, 1, 1, 1, 32'h1111_0009, 1, 1);
        tbl[10] = mk(0, 0, 1, 1, 32'h1111_000A, 0, 0);
        tbl[11] = mk(0, 0, 1, 1, 32'h1111_000B, 0, 0);
        tbl[12] = mk(0, 0, 1, 1, 32'h1111_000C, 0, 0);

        reset                = 1'b1;
        icache_mem_req_valid = 1'b1;
        dcache_mem_req_valid = 1'b1;
        icache_mem_req_addr  = 32'h0000_1000;
        dcache_mem_req_addr  = 32'h0000_2000;
        dcache_mem_req_op    = 2'd1;
        dcache_mem_req_wdata = 32'hDEAD_BEEF;
        dcache_mem_req_wmask = 4'b0011;
        mem_req_ready        = 1'b1;
        mem_resp_valid       = 1'b1;
        mem_resp_data        = 32'h0;
        #3;
        chk("mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("icache_ready", 32'(icache_mem_req_ready), 32'd0);
        chk("dcache_ready", 32'(dcache_mem_req_ready), 32'd0);
        chk("icache_resp_valid", 32'(icache_mem_resp_valid), 32'd0);
        chk("dcache_resp_valid", 32'(dcache_mem_resp_valid), 32'd0);
        chk("outstanding", 32'(outstanding), 32'd0);
        chk("proto_err", 32'(proto_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        tag = "table";
        for (int i = 0; i < 13; i++)
            step(tbl[i].iv, tbl[i].dv, tbl[i].mr, tbl[i].rv, tbl[i].rdata, tbl[i].exp_mv, tbl[i].exp_gnt);

        // Stalled dcache request keeps the grant although icache would win the tie.
        tag = "lock";
        dcache_mem_req_addr = 32'h0000_0100;
        step(0, 1, 0, 0, 32'h0, 1, 1);
        step(1, 1, 0, 0, 32'h0, 1, 1);
        step(1, 1, 0, 0, 32'h0, 1, 1);
        step(1, 1, 1, 0, 32'h0, 1, 1);
        dcache_mem_req_addr = 32'h0000_2000;
        step(1, 1, 1, 0, 32'h0, 1, 0);
        drain(2);

        tag = "inorder";
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(0, 1, 1, 0, 32'h0, 1, 1);
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(0, 0, 1, 1, 32'h0000_AAAA, 0, 0);
        step(0, 0, 1, 1, 32'h0000_0000, 0, 0);
        step(0, 0, 1, 1, 32'h0000_CCCC, 0, 0);

        tag = "full_wrap";
        step(0, 1, 1, 0, 32'h0, 1, 1);
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(0, 1, 1, 0, 32'h0, 1, 1);
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(1, 0, 1, 1, 32'h2222_0001, 0, 0);
        step(1, 1, 1, 1, 32'h2222_0002, 1, 1);
        step(1, 1, 1, 1, 32'h2222_0003, 1, 0);
        step(1, 1, 1, 1, 32'h2222_0004, 1, 1);
        step(0, 0, 1, 1, 32'h2222_0005, 0, 0);
        step(0, 0, 1, 1, 32'h2222_0006, 0, 0);
        step(1, 1, 1, 0, 32'h0,         1, 0);
        step(1, 1, 1, 1, 32'h2222_0007, 1, 1);
        step(1, 1, 1, 0, 32'h0,         1, 0);
        step(1, 1, 1, 1, 32'h2222_0008, 1, 1);
        step(1, 1, 1, 0, 32'h0,         1, 0);
        step(1, 1, 1, 1, 32'h2222_0009, 0, 0);
        step(1, 1, 1, 0, 32'h0,         1, 1);
        drain(4);

        tag = "proto";
        step(0, 0, 1, 1, 32'h3333_3333, 0, 0);
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(0, 1, 0, 0, 32'h0, 1, 1);

        // Reset between edges with three in flight and a dcache lock pending.
        tag = "async_reset";
        icache_mem_req_valid = 1'b1;
        dcache_mem_req_valid = 1'b1;
        mem_req_ready        = 1'b1;
        mem_resp_valid       = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("outstanding", 32'(outstanding), 32'd0);
        chk("proto_err", 32'(proto_err), 32'd0);
        chk("mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("icache_ready", 32'(icache_mem_req_ready), 32'd0);
        chk("dcache_ready", 32'(dcache_mem_req_ready), 32'd0);
        chk("icache_resp_valid", 32'(icache_mem_resp_valid), 32'd0);
        chk("dcache_resp_valid", 32'(dcache_mem_resp_valid), 32'd0);
        mem_resp_valid = 1'b0;
        sb.delete();
        exp_proto = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        step(1, 1, 1, 0, 32'h0, 1, 0);
        drain(1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
